// File: rtl/updown_counter_param.sv
// Parametrised up/down/load counter with wrap or saturate mode, per-cycle step,
// sticky overflow/underflow flags and a compare-match pulse; all outputs registered.
module updown_counter_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'(1) << WIDTH,
  parameter bit              SATURATE = 1'b0,
  parameter int unsigned     STEP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  in,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  cmp_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  out,
  output logic              wrap,
  output logic              ovf,
  output logic              unf,
  output logic              match
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [XW-1:0] MAX_V = XW'(MODULUS - 64'd1);
  localparam logic [XW-1:0] MOD_V = XW'(MODULUS);

  // One extra bit so boundary crossings are detected before truncation.
  logic [XW-1:0] cur_x;
  logic [XW-1:0] step_x;
  logic [XW-1:0] in_x;
  logic [XW-1:0] sum_x;

  assign cur_x  = {1'b0, out};
  assign step_x = XW'(step);
  assign in_x   = {1'b0, in};
  assign sum_x  = cur_x + step_x;

  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;
  logic             match_nxt;
  logic             ovf_evt;
  logic             unf_evt;

  // Next count value and the events it produces.
  always_comb begin
    out_nxt   = out;
    wrap_nxt  = 1'b0;
    match_nxt = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (enable) begin
      if (load) begin
        out_nxt = (in_x > MAX_V) ? WIDTH'(MAX_V) : in;
      end else if (step != '0) begin
        if (up_down) begin
          if (sum_x > MAX_V) begin
            wrap_nxt = 1'b1;
            ovf_evt  = 1'b1;
            out_nxt  = SATURATE ? WIDTH'(MAX_V) : WIDTH'(sum_x - MOD_V);
          end else begin
            out_nxt = WIDTH'(sum_x);
          end
        end else begin
          if (step_x > cur_x) begin
            wrap_nxt = 1'b1;
            unf_evt  = 1'b1;
            out_nxt  = SATURATE ? '0 : WIDTH'(cur_x + MOD_V - step_x);
          end else begin
            out_nxt = WIDTH'(cur_x - step_x);
          end
        end
        match_nxt = (out_nxt == cmp_val);
      end
    end
  end

  // A same-edge event beats clr_flags, so the sticky flag stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      wrap  <= 1'b0;
      match <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      out   <= out_nxt;
      wrap  <= wrap_nxt;
      match <= match_nxt;
      ovf   <= (ovf & ~clr_flags) | ovf_evt;
      unf   <= (unf & ~clr_flags) | unf_evt;
    end
  end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised synchronous up/down/load counter: the next-generation counter for the design's timing and sequencing logic. It adds configurable width and modulus, wrap or saturate mode, a per-cycle step size, sticky overflow/underflow flags and a compare-match pulse. It drives event timers and address sequencers directly from registered outputs.

## Interface
- WIDTH, 8: counter width in bits; range 2..32.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; range 2..2**WIDTH.
- SATURATE, 0: 0 = wrap modulo MODULUS; 1 = clamp at 0 / MODULUS-1.
- STEP_W, 4: width of step input; constraint 2**STEP_W <= MODULUS.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; unconditional (not gated by enable).
- enable  in  1  gates load and count; when low, out and flags hold.
- load  in  1  when enable=1, out <= in (clamped) this edge.
- in  in  WIDTH  load value.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  STEP_W  increment/decrement magnitude; 0 = hold, no events.
- cmp_val  in  WIDTH  compare value for match.
- clr_flags  in  1  clears ovf/unf sticky flags.
- out  out  WIDTH  count value, registered.
- wrap  out  1  one-cycle pulse: a count crossed a boundary (wrapped or clamped).
- ovf  out  1  sticky: an up-count crossed MODULUS-1.
- unf  out  1  sticky: a down-count crossed 0.
- match  out  1  one-cycle pulse: a count (not a load) landed on cmp_val.

## Operation
- Priority per edge: rst > (enable & load) > (enable & count) > hold.
- Reset: out=0, wrap=0, ovf=0, unf=0, match=0. Reset mid-count overrides load/count on that edge.
- Load: out <= (in > MODULUS-1) ? MODULUS-1 : in. No wrap/ovf/unf/match from a load. wrap and match read 0 on the load edge.
- Count up: sum = out + step, computed in WIDTH+1 bits, no truncation before compare.
  - sum <= MODULUS-1: out <= sum.
  - sum > MODULUS-1: wrap mode out <= sum - MODULUS; saturate mode out <= MODULUS-1; wrap=1, ovf set.
- Count down: step > out: wrap mode out <= out + MODULUS - step; saturate mode out <= 0; wrap=1, unf set. Otherwise out <= out - step.
- Saturate mode at limit: an up-count at MODULUS-1 or a down-count at 0 with step>0 holds out and still pulses wrap and sets the flag.
- step=0: out unchanged, no wrap, no flag, no match.
- match = 1 on the edge where a count (step>0) produces a next out equal to cmp_val. This includes a wrap/clamp landing on cmp_val.
- Flags: clr_flags clears ovf/unf. A same-edge new event wins, so the flag stays 1. clr_flags acts regardless of enable. rst also clears the flags.
- enable=0: out, ovf and unf hold; wrap=0 and match=0.

## Timing
- All outputs registered. out, wrap and match update on the same edge, so wrap/match are aligned with the new out value.
- Latency: input to out change is 1 cycle. No combinational input-to-output paths.
- Pulses last exactly one cycle per qualifying edge. Back-to-back events produce back-to-back pulses.
- Inputs sampled only at the rising edge. No handshake; the block accepts one operation every cycle.

## Test plan
- Reset/hold: WIDTH=8, count up to 0x37, assert rst with load=1 and in=0xAA -> next edge out=0, wrap=ovf=unf=match=0. Then enable=0 for 5 cycles -> out stays 0.
- Wrap up with step: MODULUS=200, SATURATE=0, load 198, step=5, up -> out=3, wrap=1 for one cycle, ovf=1 sticky. Next edge out=8, wrap=0, ovf still 1.
- Saturate down: MODULUS=200, SATURATE=1, load 2, step=3, down -> out=0, wrap=1, unf=1. Next edge out=0, wrap=1 again.
- Flag clear race: with ovf=1, pulse clr_flags alone -> ovf=0. Then clr_flags together with an overflowing count -> ovf=1.
- Load clamp and match: MODULUS=100, load in=150 -> out=99, match=0. Then cmp_val=1, wrap mode, step=2, up -> out=1, match=1, wrap=1.
- step=0 and enable gating: step=0, up, enable=1 -> out constant, no pulses. load=1 with enable=0 -> out unchanged.
